// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU load/store path and the debug/loader port.
// Optional feature: define DMEM_ARB_LOCK_EN to add dbg_lock (exclusive debug ownership).
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                  dbg_lock,
`endif
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DBG  = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_starve, w_starve_nxt;
  logic                  r_pend;
  logic                  r_owner;
  logic [DATA_WIDTH-1:0] r_cpu_rdata, r_dbg_rdata;
  logic                  w_cpu_gnt, w_dbg_gnt;
  logic                  w_dbg_lock, w_lock;

`ifdef DMEM_ARB_LOCK_EN
  assign w_dbg_lock = dbg_lock;
`else
  assign w_dbg_lock = 1'b0;
`endif

  assign w_lock = (r_state == S_DBG) && w_dbg_lock;

  // Grants are gated by rst so outputs stay at reset values while it is held low.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dbg_gnt = 1'b0;
    if (rst) begin
      if (w_lock) begin
        w_dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        if (r_starve == MAXC) w_dbg_gnt = 1'b1;
        else                  w_cpu_gnt = 1'b1;
      end else begin
        w_cpu_gnt = cpu_req;
        w_dbg_gnt = dbg_req;
      end
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_dbg_gnt)      w_state_nxt = S_DBG;
    else if (w_cpu_gnt) w_state_nxt = S_CPU;

    w_starve_nxt = r_starve;
    if (!dbg_req || w_lock || w_dbg_gnt)
      w_starve_nxt = '0;
    else if (w_cpu_gnt && (r_starve != MAXC))
      w_starve_nxt = r_starve + 1'b1;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign mem_en    = w_cpu_gnt | w_dbg_gnt;
  assign cpu_gnt   = w_cpu_gnt;
  assign dbg_gnt   = w_dbg_gnt;
  assign cpu_stall = rst & cpu_req & ~w_cpu_gnt;

  assign cpu_rvalid = r_pend & ~r_owner;
  assign dbg_rvalid = r_pend &  r_owner;
  // Owner sees memory data directly in its rvalid cycle; otherwise its last captured word.
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : r_cpu_rdata;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : r_dbg_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_starve    <= '0;
      r_pend      <= 1'b0;
      r_owner     <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_pend   <= mem_en & ~mem_we;
      r_owner  <= w_dbg_gnt;
      if (cpu_rvalid) r_cpu_rdata <= mem_rdata;
      if (dbg_rvalid) r_dbg_rdata <= mem_rdata;
    end
  end

endmodule
